// File: rtl/fb_scan_reader.sv
// Frame-buffer scan reader: turns the VGA raster position into incremental RAM read
// addresses and turns the returned pixels (gray8 / RGB332) into RGB for the DAC.
module fb_scan_reader #(
   parameter int unsigned SRC_W      = 640,
   parameter int unsigned SRC_H      = 480,
   parameter int unsigned ADDR_W     = 20,
   parameter int unsigned H_OFS      = 144,
   parameter int unsigned V_OFS      = 36,
   parameter int unsigned SCALE_LOG2 = 0,
   parameter int unsigned RAM_LAT    = 1,
   parameter logic [7:0]  BORDER     = 8'h00
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [10:0]       x,
   input  logic [10:0]       y,
   input  logic              ativo,
   input  logic              fmt_rgb332,
   output logic [ADDR_W-1:0] read_addr,
   output logic              re,
   input  logic [7:0]        data_in,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              frame_start
);

   localparam int unsigned H_END    = H_OFS + (SRC_W << SCALE_LOG2);
   localparam int unsigned V_END    = V_OFS + (SRC_H << SCALE_LOG2);
   localparam logic [1:0]  SUB_LAST = 2'((1 << SCALE_LOG2) - 1);

   logic              in_img_c;
   logic              border_c;
   logic              first_col_c;
   logic              first_line_c;
   logic              vblank_c;
   logic              line_end_c;
   logic [ADDR_W-1:0] cur_col_c;
   logic [1:0]        cur_sub_c;

   logic [ADDR_W-1:0] col;
   logic [1:0]        sub_col;
   logic [ADDR_W-1:0] line_base;
   logic [1:0]        sub_line;
   logic              line_hit;
   logic              ativo_d;
   logic              fmt_q;
   logic [RAM_LAT:0]  img_pipe;
   logic [RAM_LAT:0]  brd_pipe;

   logic [7:0]        r_c;
   logic [7:0]        g_c;
   logic [7:0]        b_c;

   // Raster decode; the column counters restart at the left edge of the image.
   always_comb begin
      in_img_c     = ativo
                     && (16'(x) >= 16'(H_OFS)) && (16'(x) < 16'(H_END))
                     && (16'(y) >= 16'(V_OFS)) && (16'(y) < 16'(V_END));
      border_c     = ativo && !in_img_c;
      first_col_c  = (16'(x) == 16'(H_OFS));
      first_line_c = (16'(y) == 16'(V_OFS));
      vblank_c     = (16'(y) < 16'(V_OFS));
      line_end_c   = ativo_d && !ativo;
      cur_col_c    = first_col_c ? '0 : col;
      cur_sub_c    = first_col_c ? 2'd0 : sub_col;
   end

   // Stage 0: address generation plus line/frame stepping by accumulation.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         read_addr   <= '0;
         re          <= 1'b0;
         frame_start <= 1'b0;
         col         <= '0;
         sub_col     <= 2'd0;
         line_base   <= '0;
         sub_line    <= 2'd0;
         line_hit    <= 1'b0;
         ativo_d     <= 1'b0;
         fmt_q       <= 1'b0;
      end else begin
         ativo_d     <= ativo;
         frame_start <= in_img_c && first_col_c && first_line_c;
         re          <= in_img_c;
         if (in_img_c) begin
            read_addr <= line_base + cur_col_c;
            line_hit  <= 1'b1;
            if (cur_sub_c == SUB_LAST) begin
               sub_col <= 2'd0;
               col     <= cur_col_c + ADDR_W'(1);
            end else begin
               sub_col <= cur_sub_c + 2'd1;
               col     <= cur_col_c;
            end
            if (first_col_c && first_line_c) fmt_q <= fmt_rgb332;
         end
         if (vblank_c) begin
            line_base <= '0;
            sub_line  <= 2'd0;
            line_hit  <= 1'b0;
         end else if (line_end_c && line_hit) begin
            line_hit <= 1'b0;
            if (sub_line == SUB_LAST) begin
               sub_line  <= 2'd0;
               line_base <= line_base + ADDR_W'(SRC_W);
            end else begin
               sub_line <= sub_line + 2'd1;
            end
         end
      end
   end

   // Valid/border flags delayed to line up with data_in.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         img_pipe <= '0;
         brd_pipe <= '0;
      end else begin
         img_pipe <= {img_pipe[RAM_LAT-1:0], in_img_c};
         brd_pipe <= {brd_pipe[RAM_LAT-1:0], border_c};
      end
   end

   // Pixel format expansion and border/blank selection.
   always_comb begin
      r_c = 8'h00;
      g_c = 8'h00;
      b_c = 8'h00;
      if (img_pipe[RAM_LAT]) begin
         if (fmt_q) begin
            r_c = {data_in[7:5], data_in[7:5], data_in[7:6]};
            g_c = {data_in[4:2], data_in[4:2], data_in[4:3]};
            b_c = {4{data_in[1:0]}};
         end else begin
            r_c = data_in;
            g_c = data_in;
            b_c = data_in;
         end
      end else if (brd_pipe[RAM_LAT]) begin
         r_c = BORDER;
         g_c = BORDER;
         b_c = BORDER;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vga_r <= 8'h00;
         vga_g <= 8'h00;
         vga_b <= 8'h00;
      end else begin
         vga_r <= r_c;
         vga_g <= g_c;
         vga_b <= b_c;
      end
   end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader: three instances (scale/latency/border variants) share one
// raster; a reference model feeds per-instance scoreboards.
module tb_fb_scan_reader;

   localparam int SRC_W     = 4;
   localparam int SRC_H     = 2;
   localparam int ADDR_W    = 8;
   localparam int H_OFS     = 2;
   localparam int V_OFS     = 2;
   localparam int H_ACT_END = 12;
   localparam int H_TOT     = 16;
   localparam int V_ACT_END = 8;
   localparam int V_TOT     = 10;
   localparam int NI        = 3;

   typedef struct {
      logic        chk;
      int          px;
      int          py;
      logic [23:0] rgb;
   } pix_t;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [10:0]       x;
   logic [10:0]       y;
   logic              ativo;
   logic              fmt_rgb332;
   logic [ADDR_W-1:0] addr_o [NI];
   logic              re_o   [NI];
   logic [7:0]        din    [NI];
   logic [7:0]        r_o    [NI];
   logic [7:0]        g_o    [NI];
   logic [7:0]        b_o    [NI];
   logic              fs_o   [NI];
   logic [7:0]        mem    [256];

   pix_t              q         [NI][$];
   logic [ADDR_W-1:0] last_addr [NI];
   logic              hold_ok   [NI];
   int                skip      [NI];
   int                fs_cnt    [NI];
   logic [23:0]       obs       [NI][V_TOT][H_TOT];
   logic              fmt_frame;
   int                n_checks = 0;
   int                n_pass   = 0;

   always #5 clk = ~clk;

   // Instance 0: scale 1x, latency 1, border 40. Instance 1: scale 2x, latency 2. Instance 2: latency 3.
   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int LAT = gi + 1;
      logic [ADDR_W-1:0] ap [LAT];

      fb_scan_reader #(
         .SRC_W     (SRC_W),
         .SRC_H     (SRC_H),
         .ADDR_W    (ADDR_W),
         .H_OFS     (H_OFS),
         .V_OFS     (V_OFS),
         .SCALE_LOG2((gi == 1) ? 1 : 0),
         .RAM_LAT   (LAT),
         .BORDER    ((gi == 0) ? 8'h40 : 8'h00)
      ) u_dut (
         .clk        (clk),
         .reset_n    (reset_n),
         .x          (x),
         .y          (y),
         .ativo      (ativo),
         .fmt_rgb332 (fmt_rgb332),
         .read_addr  (addr_o[gi]),
         .re         (re_o[gi]),
         .data_in    (din[gi]),
         .vga_r      (r_o[gi]),
         .vga_g      (g_o[gi]),
         .vga_b      (b_o[gi]),
         .frame_start(fs_o[gi])
      );

      always @(posedge clk) begin
         ap[0] <= addr_o[gi];
         for (int i = 1; i < LAT; i++) ap[i] <= ap[i - 1];
      end
      assign din[gi] = mem[ap[LAT - 1]];
   end

   function automatic int scale_of(int k);
      return (k == 1) ? 1 : 0;
   endfunction

   function automatic int lat_of(int k);
      return k + 1;
   endfunction

   function automatic logic [7:0] border_of(int k);
      return (k == 0) ? 8'h40 : 8'h00;
   endfunction

   function automatic logic model_img(int k, int xx, int yy, logic a);
      int s;
      s = scale_of(k);
      return a && (xx >= H_OFS) && (xx < H_OFS + (SRC_W << s))
               && (yy >= V_OFS) && (yy < V_OFS + (SRC_H << s));
   endfunction

   function automatic logic [ADDR_W-1:0] model_addr(int k, int xx, int yy);
      int s;
      s = scale_of(k);
      return ADDR_W'(((yy - V_OFS) >>> s) * SRC_W + ((xx - H_OFS) >>> s));
   endfunction

   function automatic logic [23:0] model_pix(int k, logic img, logic a, logic f, logic [7:0] d);
      int r3;
      int g3;
      int b2;
      r3 = int'(d[7:5]);
      g3 = int'(d[4:2]);
      b2 = int'(d[1:0]);
      if (img && f)
         return {8'((r3 << 5) | (r3 << 2) | (r3 >> 1)),
                 8'((g3 << 5) | (g3 << 2) | (g3 >> 1)),
                 8'(b2 * 85)};
      else if (img)
         return {d, d, d};
      else if (a)
         return {3{border_of(k)}};
      return 24'h0;
   endfunction

   // One raster cycle: push expectations, clock, check stage 0 now and pixels at their latency.
   task automatic drive_cycle(input int xx, input int yy, input logic a, input logic f, input logic chk);
      logic              img [NI];
      logic [ADDR_W-1:0] ea  [NI];
      logic              efs;
      pix_t              e;
      pix_t              p;
      x          = 11'(xx);
      y          = 11'(yy);
      ativo      = a;
      fmt_rgb332 = f;
      if (a && xx == H_OFS && yy == V_OFS) fmt_frame = f;
      for (int k = 0; k < NI; k++) begin
         img[k] = model_img(k, xx, yy, a);
         ea[k]  = model_addr(k, xx, yy);
         e.chk  = chk;
         e.px   = xx;
         e.py   = yy;
         e.rgb  = model_pix(k, img[k], a, fmt_frame, mem[ea[k]]);
         q[k].push_back(e);
         if (img[k]) begin
            last_addr[k] = ea[k];
            if (chk) hold_ok[k] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         fs_cnt[k] += int'(fs_o[k]);
         if (chk) begin
            efs = img[k] && xx == H_OFS && yy == V_OFS;
            n_checks++;
            if (re_o[k] !== img[k])
               $display("FAIL re u%0d x=%0d y=%0d got %0b want %0b", k, xx, yy, re_o[k], img[k]);
            else n_pass++;
            n_checks++;
            if (fs_o[k] !== efs)
               $display("FAIL frame_start u%0d x=%0d y=%0d got %0b want %0b", k, xx, yy, fs_o[k], efs);
            else n_pass++;
            if (hold_ok[k]) begin
               n_checks++;
               if (addr_o[k] !== last_addr[k])
                  $display("FAIL read_addr u%0d x=%0d y=%0d got %0d want %0d", k, xx, yy, addr_o[k], last_addr[k]);
               else n_pass++;
            end
         end
         if (q[k].size() == lat_of(k) + 2) begin
            p = q[k].pop_front();
            obs[k][p.py][p.px] = {r_o[k], g_o[k], b_o[k]};
            if (skip[k] > 0) skip[k]--;
            else if (p.chk) begin
               n_checks++;
               if ({r_o[k], g_o[k], b_o[k]} !== p.rgb)
                  $display("FAIL rgb u%0d x=%0d y=%0d got %h want %h", k, p.px, p.py, {r_o[k], g_o[k], b_o[k]}, p.rgb);
               else n_pass++;
            end
         end
      end
   endtask

   task automatic drive_frame(input logic fa, input logic fb, input logic chk);
      logic a;
      for (int yy = 0; yy < V_TOT; yy++)
         for (int xx = 0; xx < H_TOT; xx++) begin
            a = (xx >= H_OFS) && (xx < H_ACT_END) && (yy >= V_OFS) && (yy < V_ACT_END);
            drive_cycle(xx, yy, a, (yy > V_OFS) ? fb : fa, chk);
         end
   endtask

   task automatic test_reset;
      reset_n    = 1'b0;
      x          = 11'(H_OFS);
      y          = 11'(V_OFS);
      ativo      = 1'b1;
      fmt_rgb332 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         if (re_o[k] !== 1'b0) $display("FAIL reset_re u%0d got %0b want 0", k, re_o[k]);
         else n_pass++;
         n_checks++;
         if (addr_o[k] !== '0) $display("FAIL reset_addr u%0d got %0d want 0", k, addr_o[k]);
         else n_pass++;
         n_checks++;
         if ({r_o[k], g_o[k], b_o[k]} !== 24'h0)
            $display("FAIL reset_rgb u%0d got %h want 000000", k, {r_o[k], g_o[k], b_o[k]});
         else n_pass++;
         n_checks++;
         if (fs_o[k] !== 1'b0) $display("FAIL reset_fs u%0d got %0b want 0", k, fs_o[k]);
         else n_pass++;
         last_addr[k] = '0;
         hold_ok[k]   = 1'b1;
         skip[k]      = 0;
         fs_cnt[k]    = 0;
      end
      fmt_frame = 1'b0;
      reset_n   = 1'b1;
   endtask

   task automatic test_gray;
      int s1 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      drive_frame(1'b0, 1'b0, 1'b1);
      drive_frame(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (obs[0][2][H_OFS + i] !== {3{8'(i)}})
            $display("FAIL gray_l0 col%0d got %h want %h", i, obs[0][2][H_OFS + i], {3{8'(i)}});
         else n_pass++;
         n_checks++;
         if (obs[0][3][H_OFS + i] !== {3{8'(i + 4)}})
            $display("FAIL gray_l1 col%0d got %h want %h", i, obs[0][3][H_OFS + i], {3{8'(i + 4)}});
         else n_pass++;
      end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (obs[1][3][H_OFS + i] !== {3{8'(s1[i])}})
            $display("FAIL scale2_l1 x%0d got %h want %h", i, obs[1][3][H_OFS + i], {3{8'(s1[i])}});
         else n_pass++;
         n_checks++;
         if (obs[1][4][H_OFS + i] !== {3{8'(s1[i] + 4)}})
            $display("FAIL scale2_l2 x%0d got %h want %h", i, obs[1][4][H_OFS + i], {3{8'(s1[i] + 4)}});
         else n_pass++;
      end
   endtask

   task automatic test_rgb332;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
      mem[0] = 8'hE3;
      mem[1] = 8'h49;
      drive_frame(1'b1, 1'b1, 1'b1);
      n_checks++;
      if (obs[0][2][H_OFS] !== 24'hFF00FF)
         $display("FAIL rgb332_e3 got %h want ff00ff", obs[0][2][H_OFS]);
      else n_pass++;
      n_checks++;
      if (obs[0][2][H_OFS + 1] !== 24'h494955)
         $display("FAIL rgb332_49 got %h want 494955", obs[0][2][H_OFS + 1]);
      else n_pass++;
   endtask

   task automatic test_fmt_hold;
      drive_frame(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (obs[0][3][H_OFS] !== model_pix(0, 1'b1, 1'b1, 1'b1, mem[4]))
         $display("FAIL fmt_hold_rgb got %h want %h", obs[0][3][H_OFS], model_pix(0, 1'b1, 1'b1, 1'b1, mem[4]));
      else n_pass++;
      drive_frame(1'b0, 1'b1, 1'b1);
      n_checks++;
      if (obs[0][3][H_OFS] !== {3{mem[4]}})
         $display("FAIL fmt_hold_gray got %h want %h", obs[0][3][H_OFS], {3{mem[4]}});
      else n_pass++;
   endtask

   task automatic test_border;
      drive_frame(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (obs[0][2][6] !== 24'h404040) $display("FAIL border_right got %h want 404040", obs[0][2][6]);
      else n_pass++;
      n_checks++;
      if (obs[0][5][4] !== 24'h404040) $display("FAIL border_below got %h want 404040", obs[0][5][4]);
      else n_pass++;
      n_checks++;
      if (obs[0][2][H_ACT_END] !== 24'h0) $display("FAIL blank_h got %h want 000000", obs[0][2][H_ACT_END]);
      else n_pass++;
      n_checks++;
      if (obs[0][0][4] !== 24'h0) $display("FAIL blank_v got %h want 000000", obs[0][0][4]);
      else n_pass++;
      n_checks++;
      if (obs[2][2][6] !== 24'h0) $display("FAIL border_zero got %h want 000000", obs[2][2][6]);
      else n_pass++;
   endtask

   task automatic test_latency;
      for (int i = 0; i < 256; i++) mem[i] = 8'h80 | 8'(i);
      drive_frame(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         if (obs[k][V_OFS][H_OFS] !== 24'h808080)
            $display("FAIL first_pixel u%0d lat%0d got %h want 808080", k, lat_of(k), obs[k][V_OFS][H_OFS]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid;
      logic a;
      logic after;
      after = 1'b0;
      for (int yy = 0; yy < V_TOT; yy++)
         for (int xx = 0; xx < H_TOT; xx++) begin
            a = (xx >= H_OFS) && (xx < H_ACT_END) && (yy >= V_OFS) && (yy < V_ACT_END);
            if (yy == V_OFS && xx == H_OFS + 2) begin
               reset_n = 1'b0;
               for (int k = 0; k < NI; k++) skip[k] = q[k].size() + 1;
               drive_cycle(xx, yy, a, 1'b0, 1'b0);
               for (int k = 0; k < NI; k++) begin
                  n_checks++;
                  if ({re_o[k], fs_o[k], r_o[k], g_o[k], b_o[k], addr_o[k]} !== '0)
                     $display("FAIL midreset_zero u%0d got re=%0b fs=%0b rgb=%h addr=%0d want all 0",
                              k, re_o[k], fs_o[k], {r_o[k], g_o[k], b_o[k]}, addr_o[k]);
                  else n_pass++;
                  hold_ok[k] = 1'b0;
               end
               fmt_frame = 1'b0;
               reset_n   = 1'b1;
               after     = 1'b1;
            end else begin
               drive_cycle(xx, yy, a, 1'b0, !after);
            end
         end
      for (int k = 0; k < NI; k++) fs_cnt[k] = 0;
      drive_frame(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < NI; k++) begin
         n_checks++;
         if (fs_cnt[k] !== 1) $display("FAIL frame_start_count u%0d got %0d want 1", k, fs_cnt[k]);
         else n_pass++;
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      x          = '0;
      y          = '0;
      ativo      = 1'b0;
      fmt_rgb332 = 1'b0;
      fmt_frame  = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      test_reset;
      test_gray;
      test_rgb332;
      test_fmt_hold;
      test_border;
      test_latency;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
